// File: rtl/pio_din_arbiter_pkg.sv
// Shared types and constants for the PIO data-in arbiter.
package pio_din_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Offset of the PIO data register; idle address parks here.
  localparam int unsigned PIO_DATA_OFFSET = 0;

  // Width of a requester index, never narrower than one bit.
  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_din_arbiter_if.sv
// Requester-side handshake bus: requesters are masters, the arbiter is the slave.
interface pio_din_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;

  modport master (
    output req_valid, req_write, req_address, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/pio_din_arbiter_rr_arbiter.sv
// Round-robin picker: first active request after last_grant, wrapping.
module pio_din_arbiter_rr_arbiter
  import pio_din_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned GRANT_W = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [GRANT_W-1:0] grant_idx_c,
  output logic               any_c
);

  logic [GRANT_W-1:0] pick;

  // Scan from last_grant+1 so the previous winner ends up lowest priority.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    pick        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      pick = GRANT_W'((32'(last_grant) + i) % NUM_REQ);
      if (!any_c && req[pick]) begin
        any_c       = 1'b1;
        grant_idx_c = pick;
      end
    end
    if (any_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/pio_din_arbiter.sv
// Shares one zero-latency PIO slave among NUM_REQ requesters, one transaction per 3 cycles.
module pio_din_arbiter
  import pio_din_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 2,
  localparam int unsigned GRANT_W = grant_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  pio_din_arbiter_if.slave    bus,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [ADDR_W-1:0]   pio_address,
  output logic [DATA_W-1:0]   pio_writedata,
  input  logic [DATA_W-1:0]   pio_readdata,
  output logic [GRANT_W-1:0]  grant_id,
  output logic                busy
);

  state_t state;
  state_t state_nxt;

  logic [GRANT_W-1:0] last_grant;
  logic               is_write;

  logic [NUM_REQ-1:0] arb_grant_c;
  logic [GRANT_W-1:0] arb_idx_c;
  logic               arb_any_c;

  logic               cs_d;
  logic               write_n_d;
  logic [ADDR_W-1:0]  address_d;
  logic [DATA_W-1:0]  writedata_d;
  logic [NUM_REQ-1:0] ready_d;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [DATA_W-1:0]  rdata_d;
  logic [GRANT_W-1:0] grant_id_d;
  logic [GRANT_W-1:0] last_grant_d;
  logic               is_write_d;

  pio_din_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .grant_c     (arb_grant_c),
    .grant_idx_c (arb_idx_c),
    .any_c       (arb_any_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: IDLE waits for a request, ISSUE and RESP last one cycle each.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_any_c) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the bus cycle is set up on the grant edge.
  always_comb begin
    cs_d         = 1'b0;
    write_n_d    = 1'b1;
    address_d    = ADDR_W'(PIO_DATA_OFFSET);
    writedata_d  = '0;
    ready_d      = '0;
    resp_valid_d = '0;
    rdata_d      = bus.resp_rdata;
    grant_id_d   = grant_id;
    last_grant_d = last_grant;
    is_write_d   = is_write;
    unique case (state)
      IDLE: begin
        if (arb_any_c) begin
          cs_d         = 1'b1;
          write_n_d    = ~bus.req_write[arb_idx_c];
          address_d    = bus.req_address[32'(arb_idx_c)*ADDR_W +: ADDR_W];
          writedata_d  = bus.req_wdata[32'(arb_idx_c)*DATA_W +: DATA_W];
          ready_d      = arb_grant_c;
          grant_id_d   = arb_idx_c;
          last_grant_d = arb_idx_c;
          is_write_d   = bus.req_write[arb_idx_c];
        end
      end
      ISSUE: begin
        resp_valid_d = NUM_REQ'(1) << grant_id;
        rdata_d      = is_write ? '0 : pio_readdata;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= ADDR_W'(PIO_DATA_OFFSET);
      pio_writedata  <= '0;
      bus.req_ready  <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      grant_id       <= '0;
      last_grant     <= GRANT_W'(NUM_REQ - 1);
      is_write       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      pio_chipselect <= cs_d;
      pio_write_n    <= write_n_d;
      pio_address    <= address_d;
      pio_writedata  <= writedata_d;
      bus.req_ready  <= ready_d;
      bus.resp_valid <= resp_valid_d;
      bus.resp_rdata <= rdata_d;
      grant_id       <= grant_id_d;
      last_grant     <= last_grant_d;
      is_write       <= is_write_d;
      busy           <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_pio_din_arbiter.sv
// Self-checking bench: directed table, hand-written corner sequences, random traffic vs. a reference model.
module tb_pio_din_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned GRANT_W = 1;

  logic clk = 1'b0;
  logic reset;
  logic pio_chipselect;
  logic pio_write_n;
  logic [ADDR_W-1:0]  pio_address;
  logic [DATA_W-1:0]  pio_writedata;
  logic [DATA_W-1:0]  pio_readdata;
  logic [GRANT_W-1:0] grant_id;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  pio_din_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pio_din_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_address    (pio_address),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // PIO slave: one data register at address 0, other addresses read as zero.
  logic [DATA_W-1:0] pio_reg = '0;
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == '0) pio_reg <= pio_writedata;
  end
  assign pio_readdata = (pio_address == '0) ? pio_reg : '0;

  // Requester state driven onto the bus.
  logic [NUM_REQ-1:0] pend = '0;
  logic               p_wr    [NUM_REQ];
  logic [ADDR_W-1:0]  p_addr  [NUM_REQ];
  logic [DATA_W-1:0]  p_wdata [NUM_REQ];

  // Reference model state.
  int unsigned       model_last;
  logic [DATA_W-1:0] model_store = '0;

  typedef struct {
    int unsigned       r;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = p_wr[i];
      bus.req_address[i*ADDR_W +: ADDR_W] = p_addr[i];
      bus.req_wdata[i*DATA_W +: DATA_W]   = p_wdata[i];
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int unsigned g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first pending requester after the last winner, wrapping.
  function automatic int unsigned rr_pick(input logic [NUM_REQ-1:0] p, input int unsigned last);
    int unsigned idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".cs"},    pio_chipselect, 1'b0);
    check({tag, ".wr_n"},  pio_write_n,    1'b1);
    check({tag, ".addr"},  pio_address,    '0);
    check({tag, ".wdata"}, pio_writedata,  '0);
    check({tag, ".ready"}, bus.req_ready,  '0);
  endtask

  // Single-requester transaction from IDLE through ISSUE, RESP and back.
  task automatic do_txn(input string tag, input int unsigned r, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] exp_rd);
    pend = '0;
    pend[r] = 1'b1;
    p_wr[r] = wr;
    p_addr[r] = a;
    p_wdata[r] = d;
    drive();
    tick();
    check({tag, ".cs"},     pio_chipselect, 1'b1);
    check({tag, ".wr_n"},   pio_write_n,    !wr);
    check({tag, ".addr"},   pio_address,    a);
    check({tag, ".wdata"},  pio_writedata,  d);
    check({tag, ".ready"},  bus.req_ready,  onehot(r));
    check({tag, ".grant"},  grant_id,       GRANT_W'(r));
    check({tag, ".busy"},   busy,           1'b1);
    check({tag, ".rv_iss"}, bus.resp_valid, '0);
    pend[r] = 1'b0;
    drive();
    tick();
    check({tag, ".rvalid"}, bus.resp_valid, onehot(r));
    check({tag, ".rdata"},  bus.resp_rdata, exp_rd);
    check({tag, ".cs_rsp"}, pio_chipselect, 1'b0);
    check({tag, ".rdy_rsp"}, bus.req_ready, '0);
    tick();
    check({tag, ".rv_end"}, bus.resp_valid, '0);
    check({tag, ".busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev_cyc;
    int unsigned grants;
    int unsigned exp_g;
    logic        seen;
    logic        got;
    logic [DATA_W-1:0] exp_rd;

    for (int i = 0; i < NUM_REQ; i++) begin
      p_wr[i] = 1'b0;
      p_addr[i] = '0;
      p_wdata[i] = '0;
    end
    drive();

    // Directed vectors; expected read data follows the PIO register rule by hand.
    vecs[0] = '{r: 0, wr: 1'b1, addr: 2'd0, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
    vecs[1] = '{r: 1, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{r: 0, wr: 1'b0, addr: 2'd1, wdata: 32'h0,        exp_rdata: 32'h0};
    vecs[3] = '{r: 1, wr: 1'b1, addr: 2'd3, wdata: 32'hCAFEF00D, exp_rdata: 32'h0};
    vecs[4] = '{r: 0, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[5] = '{r: 1, wr: 1'b1, addr: 2'd0, wdata: 32'h12345678, exp_rdata: 32'h0};
    vecs[6] = '{r: 0, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp_rdata: 32'h12345678};

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check_idle_outputs("rst");
    check("rst.busy",  busy,           1'b0);
    check("rst.grant", grant_id,       '0);
    check("rst.rv",    bus.resp_valid, '0);
    check("rst.rdata", bus.resp_rdata, '0);
    reset = 1'b0;

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      do_txn($sformatf("vec%0d", v), vecs[v].r, vecs[v].wr, vecs[v].addr,
             vecs[v].wdata, vecs[v].exp_rdata);
      if (vecs[v].wr && vecs[v].addr == '0) model_store = vecs[v].wdata;
    end

    // Both requesters valid continuously from reset: alternating grants every 3 cycles.
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b1;
      p_wr[i] = 1'b0;
      p_addr[i] = '0;
    end
    drive();
    tick();
    reset = 1'b0;
    exp_g = 0;
    grants = 0;
    prev_cyc = 0;
    seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (|bus.req_ready) begin
        check($sformatf("rr.grant%0d", grants), bus.req_ready, onehot(exp_g));
        if (seen) check($sformatf("rr.gap%0d", grants), 64'(c - prev_cyc), 64'd3);
        seen = 1'b1;
        prev_cyc = c;
        exp_g = (exp_g + 1) % NUM_REQ;
        grants++;
      end
    end
    check("rr.count", grants, 4);
    pend = '0;
    drive();
    tick();
    tick();
    tick();

    // Reset during ISSUE: no response, and requester 0 regains first priority.
    do_txn("pre_rst", 0, 1'b0, 2'd0, 32'h0, model_store);
    pend[1] = 1'b1;
    p_wr[1] = 1'b0;
    p_addr[1] = '0;
    drive();
    tick();
    check("mid.ready_iss", bus.req_ready, onehot(1));
    reset = 1'b1;
    tick();
    check_idle_outputs("mid");
    check("mid.busy",  busy,           1'b0);
    check("mid.rv",    bus.resp_valid, '0);
    check("mid.grant", grant_id,       '0);
    check("mid.rdata", bus.resp_rdata, '0);
    pend[0] = 1'b1;
    p_wr[0] = 1'b0;
    p_addr[0] = '0;
    drive();
    reset = 1'b0;
    tick();
    check("mid.first",   bus.req_ready, onehot(0));
    check("mid.first_g", grant_id,      '0);
    pend[0] = 1'b0;
    drive();
    tick();
    check("mid.rv0", bus.resp_valid, onehot(0));
    tick();
    tick();
    check("mid.second", bus.req_ready, onehot(1));
    pend[1] = 1'b0;
    drive();
    tick();
    check("mid.rv1",    bus.resp_valid, onehot(1));
    check("mid.rdata1", bus.resp_rdata, model_store);
    tick();

    // Quiet bus stays idle.
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("quiet.cs%0d", c),   pio_chipselect, 1'b0);
      check($sformatf("quiet.busy%0d", c), busy,           1'b0);
    end

    // Random traffic against the reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last = NUM_REQ - 1;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]    = 1'b1;
          p_wr[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = ($urandom_range(0, 1) == 1) ? '0 : ADDR_W'($urandom);
          p_wdata[i] = $urandom;
        end
      end
      drive();
      if (pend == '0) begin
        tick();
        check("rnd.idle_cs", pio_chipselect, 1'b0);
        continue;
      end
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick();
        if (|bus.req_ready) got = 1'b1;
      end
      exp_g = rr_pick(pend, model_last);
      check($sformatf("rnd%0d.ready", it), bus.req_ready, onehot(exp_g));
      if (got) begin
        check($sformatf("rnd%0d.cs", it),    pio_chipselect, 1'b1);
        check($sformatf("rnd%0d.wr_n", it),  pio_write_n,    !p_wr[exp_g]);
        check($sformatf("rnd%0d.addr", it),  pio_address,    p_addr[exp_g]);
        check($sformatf("rnd%0d.wdata", it), pio_writedata,  p_wdata[exp_g]);
        check($sformatf("rnd%0d.grant", it), grant_id,       GRANT_W'(exp_g));
        if (p_wr[exp_g]) begin
          exp_rd = '0;
          if (p_addr[exp_g] == '0) model_store = p_wdata[exp_g];
        end else begin
          exp_rd = (p_addr[exp_g] == '0) ? model_store : '0;
        end
        model_last = exp_g;
        pend[exp_g] = 1'b0;
        drive();
        tick();
        check($sformatf("rnd%0d.rvalid", it), bus.resp_valid, onehot(exp_g));
        check($sformatf("rnd%0d.rdata", it),  bus.resp_rdata, exp_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
